// File: rtl/seq_shift_right.sv
// seq_shift_right: bit-serial right shifter (logical or arithmetic).
// A start loads the operand and shift amount. The result register then
// shifts right by one bit per cycle until the remaining count is used up.
// o_done pulses for one cycle when the result is final.
module seq_shift_right #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic               i_arith,
  output logic               o_busy,
  output logic               o_done,
  output logic [WIDTH-1:0]   o_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q,  data_d;
  logic [SHAMT_W-1:0] cnt_q,   cnt_d;
  logic               fill_q,  fill_d;

  // A start is only honoured outside SHIFT. Reset is asynchronous, so no
  // edge that sees i_rst high can accept a start.
  logic start_ok;
  assign start_ok = i_start && (state_q != SHIFT);

  // Next-state logic: load on an accepted start, otherwise shift or wind down.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          data_d  = i_data;
          cnt_d   = i_shamt;
          fill_d  = i_arith & i_data[WIDTH-1];
          state_d = (i_shamt == '0) ? DONE : SHIFT;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        data_d = {fill_q, data_q[WIDTH-1:1]};
        // Saturate at zero so the count can never wrap.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - SHAMT_W'(1);
        end
        // This edge performs the last shift.
        if (cnt_q <= SHAMT_W'(1)) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
    end
  end

  // The outputs are decoded directly from the registered state, so reset
  // clears them immediately.
  always_comb begin
    o_busy = (state_q == SHIFT);
    o_done = (state_q == DONE);
    o_data = data_q;
  end

endmodule

// File: doc/seq_shift_right.md
SEQ_SHIFT_RIGHT -- requirements
Module: seq_shift_right

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the data word width in bits.
REQ-002 The block SHALL have parameter SHAMT_W, default 5, the shift-amount width, with WIDTH = 2**SHAMT_W.
REQ-003 The block SHALL have port i_clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1, the reset; it is asynchronous and active-high.
REQ-005 The block SHALL have port i_start, input, 1, a request to begin a shift, sampled on a rising edge.
REQ-006 The block SHALL have port i_data, input, WIDTH, the operand, captured when a start is accepted.
REQ-007 The block SHALL have port i_shamt, input, SHAMT_W, the unsigned shift amount, captured when a start is accepted.
REQ-008 The block SHALL have port i_arith, input, 1: 1 selects arithmetic right shift (sra), 0 selects logical right shift (srl); captured when a start is accepted.
REQ-009 The block SHALL have port o_busy, output, 1, high while a shift is in progress.
REQ-010 The block SHALL have port o_done, output, 1, a one-cycle pulse when the result is valid.
REQ-011 The block SHALL have port o_data, output, WIDTH, the result register.

Function
REQ-012 The block SHALL implement three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE or DONE, i_start=1 SHALL be accepted: it loads i_data into o_data, loads i_shamt into the remaining-count register, and captures the fill bit (i_data[WIDTH-1] when i_arith=1, otherwise 0).
REQ-014 On an accepted start with i_shamt != 0, the next state SHALL be SHIFT; with i_shamt = 0, the next state SHALL be DONE with o_data = i_data.
REQ-015 In SHIFT, each cycle SHALL shift o_data right by one bit, insert the captured fill bit at the MSB, and decrement the count by one.
REQ-016 SHIFT SHALL move to DONE on the edge that performs the final shift (count = 1); the count SHALL never wrap below 0.
REQ-017 o_done SHALL be high exactly while in DONE, a single cycle; DONE SHALL move to IDLE unless a new start is accepted.
REQ-018 Latency SHALL be: o_done asserts i_shamt+1 rising edges after the edge that accepts the start (shamt = 0 gives 1; shamt = 31 gives 32).
REQ-019 o_busy SHALL be high exactly while in SHIFT.
REQ-020 While in SHIFT, i_start SHALL be ignored, and changes on i_data, i_shamt and i_arith SHALL have no effect.
REQ-021 o_data SHALL hold the last result from DONE through IDLE until the next accepted start.
REQ-022 The final o_data SHALL equal i_data >> i_shamt (srl) or the sign-extended i_data >>> i_shamt (sra), computed on the captured values.
REQ-023 A start accepted in DONE SHALL be handled exactly as one accepted in IDLE; o_done is still high that cycle for the previous result.

Reset
REQ-024 While i_rst=1, the block SHALL asynchronously force state = IDLE, o_data = 0, count = 0, fill = 0, o_busy = 0 and o_done = 0, regardless of i_clk.
REQ-025 Asserting i_rst mid-SHIFT SHALL abort the operation with no o_done pulse; the first start after release SHALL behave as from power-up.
REQ-026 i_start SHALL be ignored on any edge where i_rst=1.

Verification
REQ-027 i_data=32'h8000_0000, i_shamt=4, i_arith=0, start pulse -> o_busy high for 4 cycles, o_done on edge 5, o_data=32'h0800_0000.
REQ-028 Same data, i_arith=1 -> o_data=32'hF800_0000 on the o_done cycle.
REQ-029 i_data=32'h1234_5678, i_shamt=0 -> o_done on the next edge, o_busy never high, o_data=32'h1234_5678.
REQ-030 i_data=32'hFFFF_FFFF, i_shamt=31: i_arith=0 -> o_data=32'h0000_0001 after 32 cycles; i_arith=1 -> o_data=32'hFFFF_FFFF.
REQ-031 A start held high during SHIFT with new data -> no effect until DONE; back-to-back start in DONE -> second result correct, with o_done pulsing once per operation.
REQ-032 i_rst asserted asynchronously on the 3rd SHIFT cycle of a shamt=8 operation -> outputs 0 immediately, no o_done; after release, a new shamt=2 operation completes correctly in 3 cycles.
